branch_history_predictor: RTL and testbench

- Parametrised successor to the CPU's single-counter branch predictor.
- Holds a table of ENTRIES saturating counters, indexed by PC bits, optionally XORed with a global history register (gshare mode).
- Sits beside the IF/ID stage. predict_o feeds the PC-select and IF/ID flush logic. Resolution arrives from EX, where the branch is resolved.
- Provides branch and misprediction statistics counters for the testbench dump.

---
 rtl/branch_history_predictor.sv | 153 +++++++++++++++
 tb/tb_branch_history_predictor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_predictor.sv
// ---------------------------------------------------------------------------
// branch_history_predictor
//
// Table of ENTRIES saturating counters used to predict conditional branches.
// The table index comes from the word-aligned PC bits. In gshare mode it is
// the PC bits XORed with a global history register of recent outcomes.
// Lookups are combinational. Updates arrive from EX, carrying the index that
// was produced at lookup time.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   pc_i           PC of the instruction in ID (lookup)
//   predict_o      prediction for pc_i, 1 = taken
//   lookup_idx_o   table index used for pc_i (carried down the pipeline)
//   update_i       one-cycle pulse: a branch resolved in EX
//   update_idx_i   lookup_idx_o value carried with the resolved branch
//   taken_i        actual outcome of the resolved branch
//   predicted_i    prediction that was made for the resolved branch
//   mispredict_o   update_i & (taken_i != predicted_i), combinational
//   ghr_o          global history register (always 0 when GSHARE=0)
//   branch_cnt_o   resolved branches since reset (saturating)
//   mispred_cnt_o  mispredictions since reset (saturating)
// ---------------------------------------------------------------------------
module branch_history_predictor #(
   parameter int PC_W     = 32,
   parameter int ENTRIES  = 16,
   parameter int CTR_W    = 2,
   parameter int INIT_CTR = 2**CTR_W - 1,
   parameter int GSHARE   = 0,
   parameter int CNT_W    = 32,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PC_W-1:0]  pc_i,
   output logic             predict_o,
   output logic [IDX_W-1:0] lookup_idx_o,
   input  logic             update_i,
   input  logic [IDX_W-1:0] update_idx_i,
   input  logic             taken_i,
   input  logic             predicted_i,
   output logic             mispredict_o,
   output logic [IDX_W-1:0] ghr_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Plain register array so the whole table can be observed hierarchically.
   logic [CTR_W-1:0] ctr_q [ENTRIES];
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_d;

   logic [IDX_W-1:0] ghr_q, ghr_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] base_idx;
   logic             mispredict;

   // Upper PC bits and the byte offset never take part in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_i[PC_W-1:IDX_W+2], pc_i[1:0]};

   // ------------------------------------------------------------------
   // Lookup: uses the current (pre-update) table and GHR, with no bypass.
   // ------------------------------------------------------------------
   assign base_idx     = pc_i[IDX_W+1:2];
   assign lookup_idx_o = (GSHARE != 0) ? (base_idx ^ ghr_q) : base_idx;
   assign predict_o    = ctr_q[lookup_idx_o][CTR_W-1];

   assign mispredict   = update_i & (taken_i ^ predicted_i);
   assign mispredict_o = mispredict;
   assign ghr_o        = ghr_q;
   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

   // ------------------------------------------------------------------
   // Saturating step for the counter named by the resolved branch.
   // ------------------------------------------------------------------
   always_comb begin
      ctr_cur = ctr_q[update_idx_i];
      ctr_d   = ctr_cur;
      if (taken_i) begin
         if (ctr_cur != CTR_MAX) begin
            ctr_d = ctr_cur + CTR_W'(1);
         end
      end else begin
         if (ctr_cur != '0) begin
            ctr_d = ctr_cur - CTR_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // History register: a shift of resolved outcomes, only in gshare mode.
   // ------------------------------------------------------------------
   generate
      if (GSHARE == 0) begin : g_no_ghr
         assign ghr_d = '0;
      end else if (IDX_W == 1) begin : g_ghr_1b
         assign ghr_d = update_i ? taken_i : ghr_q;
      end else begin : g_ghr
         assign ghr_d = update_i ? {ghr_q[IDX_W-2:0], taken_i} : ghr_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Statistics counters, both stick at all-ones.
   // ------------------------------------------------------------------
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (update_i) begin
         if (branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
         end
         if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (update_i) begin
         ctr_q[update_idx_i] <= ctr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ghr_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         ghr_q         <= ghr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_history_predictor.sv
// ---------------------------------------------------------------------------
// Testbench for branch_history_predictor.
// Two instances share one stimulus stream:
//   dut_a : defaults (GSHARE=0, CNT_W=32)
//   dut_b : GSHARE=1, CNT_W=4
// A per-cycle compare process checks both instances against a behavioural
// model. Directed literal expectations pin that model.
// ---------------------------------------------------------------------------
module tb_branch_history_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        update;
   logic [3:0]  update_idx;
   logic        taken;
   logic        predicted;

   logic        a_pred, b_pred;
   logic [3:0]  a_idx, b_idx;
   logic        a_mis, b_mis;
   logic [3:0]  a_ghr, b_ghr;
   logic [31:0] a_bcnt, a_mcnt;
   logic [3:0]  b_bcnt, b_mcnt;

   int n_checks = 0;
   int n_errors = 0;

   branch_history_predictor #(.GSHARE(0), .CNT_W(32)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .pc_i(pc),
      .predict_o(a_pred), .lookup_idx_o(a_idx),
      .update_i(update), .update_idx_i(update_idx),
      .taken_i(taken), .predicted_i(predicted),
      .mispredict_o(a_mis), .ghr_o(a_ghr),
      .branch_cnt_o(a_bcnt), .mispred_cnt_o(a_mcnt)
   );

   branch_history_predictor #(.GSHARE(1), .CNT_W(4)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .pc_i(pc),
      .predict_o(b_pred), .lookup_idx_o(b_idx),
      .update_i(update), .update_idx_i(update_idx),
      .taken_i(taken), .predicted_i(predicted),
      .mispredict_o(b_mis), .ghr_o(b_ghr),
      .branch_cnt_o(b_bcnt), .mispred_cnt_o(b_mcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. Each instance holds 16 plain integer counters in
   // the range 0..3, a history value in the range 0..15 (instance b only),
   // and two event tallies clipped at the output width maximum.
   // ------------------------------------------------------------------
   int      m_ctr [2][16];
   int      m_ghr [2];
   longint  m_bc  [2];
   longint  m_mc  [2];
   longint  cmax  [2];

   initial begin
      cmax[0] = 64'd4294967295;
      cmax[1] = 64'd15;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 16; e++) m_ctr[k][e] <= 3;
            m_ghr[k] <= 0;
            m_bc[k]  <= 0;
            m_mc[k]  <= 0;
         end
      end else if (update) begin
         for (int k = 0; k < 2; k++) begin
            if (taken) m_ctr[k][update_idx] <= (m_ctr[k][update_idx] >= 3) ? 3 : m_ctr[k][update_idx] + 1;
            else       m_ctr[k][update_idx] <= (m_ctr[k][update_idx] <= 0) ? 0 : m_ctr[k][update_idx] - 1;
            m_bc[k] <= (m_bc[k] >= cmax[k]) ? cmax[k] : m_bc[k] + 1;
            if (taken != predicted)
               m_mc[k] <= (m_mc[k] >= cmax[k]) ? cmax[k] : m_mc[k] + 1;
         end
         m_ghr[1] <= (m_ghr[1] * 2 + int'(taken)) % 16;
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle comparison on the falling edge.
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (!$isunknown(pc)) begin
         chk("a_lookup_idx", 64'(a_idx), 64'((pc / 4) % 16));
         chk("b_lookup_idx", 64'(b_idx), 64'(((pc / 4) % 16) ^ m_ghr[1]));
         chk("a_predict", 64'(a_pred), 64'(m_ctr[0][(pc / 4) % 16] >= 2));
         chk("b_predict", 64'(b_pred), 64'(m_ctr[1][((pc / 4) % 16) ^ m_ghr[1]] >= 2));
      end
      chk("a_mispredict", 64'(a_mis), 64'(update && (taken != predicted)));
      chk("b_mispredict", 64'(b_mis), 64'(update && (taken != predicted)));
      chk("a_ghr", 64'(a_ghr), 64'(m_ghr[0]));
      chk("b_ghr", 64'(b_ghr), 64'(m_ghr[1]));
      chk("a_branch_cnt", 64'(a_bcnt), 64'(m_bc[0]));
      chk("a_mispred_cnt", 64'(a_mcnt), 64'(m_mc[0]));
      chk("b_branch_cnt", 64'(b_bcnt), 64'(m_bc[1]));
      chk("b_mispred_cnt", 64'(b_mcnt), 64'(m_mc[1]));
      for (int e = 0; e < 16; e++) begin
         chk("a_counter", 64'(dut_a.ctr_q[e]), 64'(m_ctr[0][e]));
         chk("b_counter", 64'(dut_b.ctr_q[e]), 64'(m_ctr[1][e]));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [3:0] idx, input logic t, input logic p);
      update     = 1'b1;
      update_idx = idx;
      taken      = t;
      predicted  = p;
      tick();
      update     = 1'b0;
      $display("update idx=%0d taken=%0b predicted=%0b -> a_bcnt=%0d a_mcnt=%0d b_ghr=%b",
               idx, t, p, a_bcnt, a_mcnt, b_ghr);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      pc         = 32'h0;
      update     = 1'b0;
      update_idx = 4'h0;
      taken      = 1'b0;
      predicted  = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // 1: reset state, every entry predicts taken
      for (int i = 0; i < 16; i++) begin
         pc = 32'(i * 4);
         #2;
         chk("t1_a_predict", 64'(a_pred), 64'd1);
         chk("t1_b_predict", 64'(b_pred), 64'd1);
         $display("lookup pc=0x%02h a_pred=%0b b_pred=%0b", pc, a_pred, b_pred);
      end
      chk("t1_a_bcnt", 64'(a_bcnt), 64'd0);
      chk("t1_a_mcnt", 64'(a_mcnt), 64'd0);
      chk("t1_b_ghr", 64'(b_ghr), 64'd0);
      tick();

      // 2: four not-taken updates on idx 3, predicted taken
      pc = 32'h0C;
      upd(4'd3, 1'b0, 1'b1);
      chk("t2_ctr3_1", 64'(dut_a.ctr_q[3]), 64'd2);
      upd(4'd3, 1'b0, 1'b1);
      chk("t2_ctr3_2", 64'(dut_a.ctr_q[3]), 64'd1);
      chk("t2_pred_pc0c", 64'(a_pred), 64'd0);
      upd(4'd3, 1'b0, 1'b1);
      chk("t2_ctr3_3", 64'(dut_a.ctr_q[3]), 64'd0);
      upd(4'd3, 1'b0, 1'b1);
      chk("t2_ctr3_4", 64'(dut_a.ctr_q[3]), 64'd0);
      chk("t2_a_bcnt", 64'(a_bcnt), 64'd4);
      chk("t2_a_mcnt", 64'(a_mcnt), 64'd4);

      // 3: same-cycle lookup and update on idx 5 with counter=2
      do_reset();
      upd(4'd5, 1'b0, 1'b1);
      chk("t3_ctr5", 64'(dut_a.ctr_q[5]), 64'd2);
      pc         = 32'h14;
      update     = 1'b1;
      update_idx = 4'd5;
      taken      = 1'b0;
      predicted  = 1'b1;
      #2;
      chk("t3_pred_same_cycle", 64'(a_pred), 64'd1);
      tick();
      update = 1'b0;
      chk("t3_pred_next_cycle", 64'(a_pred), 64'd0);
      $display("same-cycle idx=5 -> next-cycle a_pred=%0b", a_pred);

      // X on pc with no update must leave state alone
      pc = 'x;
      tick();
      tick();
      pc = 32'h14;
      tick();
      chk("tx_ctr5", 64'(dut_a.ctr_q[5]), 64'd1);

      // 4: gshare history 1,0,1,1 then indexed lookup
      do_reset();
      upd(4'd0, 1'b1, 1'b1);
      upd(4'd0, 1'b0, 1'b0);
      upd(4'd0, 1'b1, 1'b1);
      upd(4'd0, 1'b1, 1'b1);
      chk("t4_b_ghr", 64'(b_ghr), 64'b1011);
      chk("t4_a_ghr", 64'(a_ghr), 64'd0);
      pc = 32'h08;
      #1;
      chk("t4_b_idx", 64'(b_idx), 64'd9);
      chk("t4_a_idx", 64'(a_idx), 64'd2);

      // 5: 20 mispredicted updates, 4-bit statistics saturate
      for (int i = 0; i < 20; i++) upd(4'd7, 1'b0, 1'b1);
      chk("t5_b_bcnt", 64'(b_bcnt), 64'd15);
      chk("t5_b_mcnt", 64'(b_mcnt), 64'd15);
      chk("t5_a_bcnt", 64'(a_bcnt), 64'd24);
      chk("t5_a_mcnt", 64'(a_mcnt), 64'd20);
      chk("t5_ctr7", 64'(dut_a.ctr_q[7]), 64'd0);

      // 6: asynchronous reset between edges while an update is pending
      update     = 1'b1;
      update_idx = 4'd7;
      taken      = 1'b1;
      predicted  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_a_bcnt_async", 64'(a_bcnt), 64'd0);
      chk("t6_b_mcnt_async", 64'(b_mcnt), 64'd0);
      chk("t6_b_ghr_async", 64'(b_ghr), 64'd0);
      chk("t6_ctr7_async", 64'(dut_a.ctr_q[7]), 64'd3);
      tick();
      update = 1'b0;
      rst_n  = 1'b1;
      tick();
      for (int e = 0; e < 16; e++) begin
         chk("t6_a_ctr_init", 64'(dut_a.ctr_q[e]), 64'd3);
      end
      chk("t6_a_bcnt", 64'(a_bcnt), 64'd0);
      $display("async reset: a_bcnt=%0d b_ghr=%b ctr7=%0d", a_bcnt, b_ghr, dut_a.ctr_q[7]);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
